pio_reg_master: RTL and testbench

- Initiator side of the PIO user-register bus: turns a command stream into wr_addr/wr_en/wr_be/wr_data writes and rd_addr/rd_be reads.
- Returns one response per command.
- Sits between an in-FPGA command source (debug console, self-test sequencer) and the PCIe user-register file, muxed with the PIO RX/TX engines.
- Handles wr_busy stall, registered read latency, register-file byte-lane ordering and a busy watchdog.

---
 rtl/pio_reg_pkg.sv | 36 +++
 rtl/pio_reg_master.sv | 182 ++++++++++++++++++
 tb/tb_pio_reg_master.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pio_reg_pkg.sv
// Shared types and constants for the PIO user-register bus: FSM encoding,
// response payload, register-file byte-lane swap and register offsets.
package pio_reg_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned WR_BE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RSP  = 2'd3
  } pio_state_e;

  typedef struct packed {
    logic              write;
    logic              err;
    logic [DATA_W-1:0] data;
  } pio_rsp_t;

  // Register offsets shared with the user-register file.
  localparam logic [7:0] REG_STATUS = 8'h00;
  localparam logic [7:0] REG_PARAM  = 8'h01;
  localparam logic [7:0] REG_ADDRH  = 8'h04;
  localparam logic [7:0] REG_ADDRL  = 8'h05;
  localparam logic [7:0] REG_LENGTH = 8'h06;
  localparam logic [7:0] REG_TX_PPS = 8'h08;
  localparam logic [7:0] REG_DEBUG1 = 8'h10;

  // The register file numbers byte enables big-endian: bit 3 selects data[7:0].
  function automatic logic [BE_W-1:0] be_swap4(input logic [BE_W-1:0] be);
    return {be[0], be[1], be[2], be[3]};
  endfunction

endpackage

// File: rtl/pio_reg_master.sv
// Initiator on the PIO user-register bus: takes one command at a time,
// performs the register write or read, and returns exactly one response.
module pio_reg_master
  import pio_reg_pkg::*;
#(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_be,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic [31:0]       rsp_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        rd_be,
  input  logic [31:0]       rd_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_be,
  output logic [31:0]       wr_data,
  output logic              wr_en,
  input  logic              wr_busy,
  output logic              busy
);

  localparam int unsigned WD_W = (BUSY_TIMEOUT > 255) ? $clog2(BUSY_TIMEOUT + 1) : 8;
  localparam int unsigned RC_W = 3;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(BUSY_TIMEOUT - 1);
  localparam logic [RC_W-1:0] RD_LAST = RC_W'(RD_LATENCY);
  localparam bit              WD_EN   = (BUSY_TIMEOUT != 0);

  pio_state_e          state, state_n;
  pio_rsp_t            rsp_q, rsp_n;
  logic                rsp_valid_q, rsp_valid_n;
  logic                cmd_ready_q, cmd_ready_n;
  logic                busy_q, busy_n;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_n;
  logic [BE_W-1:0]     rd_be_q, rd_be_n;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_n;
  logic [WR_BE_W-1:0]  wr_be_q, wr_be_n;
  logic [DATA_W-1:0]   wr_data_q, wr_data_n;
  logic [WD_W-1:0]     wd_cnt, wd_cnt_n;
  logic [RC_W-1:0]     rd_cnt, rd_cnt_n;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rd_addr_q   <= '0;
      rd_be_q     <= '0;
      wr_addr_q   <= '0;
      wr_be_q     <= '0;
      wr_data_q   <= '0;
      wd_cnt      <= '0;
      rd_cnt      <= '0;
    end else begin
      state       <= state_n;
      rsp_q       <= rsp_n;
      rsp_valid_q <= rsp_valid_n;
      cmd_ready_q <= cmd_ready_n;
      busy_q      <= busy_n;
      rd_addr_q   <= rd_addr_n;
      rd_be_q     <= rd_be_n;
      wr_addr_q   <= wr_addr_n;
      wr_be_q     <= wr_be_n;
      wr_data_q   <= wr_data_n;
      wd_cnt      <= wd_cnt_n;
      rd_cnt      <= rd_cnt_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    rsp_n     = rsp_q;
    rd_addr_n = rd_addr_q;
    rd_be_n   = rd_be_q;
    wr_addr_n = wr_addr_q;
    wr_be_n   = wr_be_q;
    wr_data_n = wr_data_q;
    wd_cnt_n  = wd_cnt;
    rd_cnt_n  = rd_cnt;

    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rsp_n = '0;
          if (cmd_write) begin
            state_n   = ST_WR;
            wr_addr_n = cmd_addr;
            wr_be_n   = {4'b0000, be_swap4(cmd_be)};
            wr_data_n = cmd_wdata;
            wd_cnt_n  = '0;
          end else begin
            state_n   = ST_RD;
            rd_addr_n = cmd_addr;
            rd_be_n   = be_swap4(cmd_be);
            rd_cnt_n  = '0;
          end
        end
      end

      ST_WR: begin
        // wr_en fires combinationally this cycle when busy is low.
        if (!wr_busy) begin
          state_n     = ST_RSP;
          rsp_n.write = 1'b1;
          rsp_n.err   = 1'b0;
          rsp_n.data  = '0;
          wr_addr_n   = '0;
          wr_be_n     = '0;
          wr_data_n   = '0;
        end else if (WD_EN && (wd_cnt == WD_LAST)) begin
          state_n     = ST_RSP;
          rsp_n.write = 1'b1;
          rsp_n.err   = 1'b1;
          rsp_n.data  = '0;
          wr_addr_n   = '0;
          wr_be_n     = '0;
          wr_data_n   = '0;
        end else if (wd_cnt != '1) begin
          wd_cnt_n = wd_cnt + WD_W'(1);
        end
      end

      ST_RD: begin
        // rd_addr is held for RD_LATENCY wait cycles plus the capture cycle.
        if (rd_cnt == RD_LAST) begin
          state_n     = ST_RSP;
          rsp_n.write = 1'b0;
          rsp_n.err   = 1'b0;
          rsp_n.data  = rd_data;
          rd_addr_n   = '0;
          rd_be_n     = '0;
        end else begin
          rd_cnt_n = rd_cnt + RC_W'(1);
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          state_n = ST_IDLE;
          rsp_n   = '0;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    cmd_ready_n = (state_n == ST_IDLE);
    rsp_valid_n = (state_n == ST_RSP);
    busy_n      = (state_n != ST_IDLE);
  end

  // wr_busy must be seen in the same cycle as the strobe, so wr_en is decoded.
  assign wr_en     = (state == ST_WR) && !wr_busy;

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_q.write;
  assign rsp_err   = rsp_q.err;
  assign rsp_data  = rsp_q.data;
  assign rd_addr   = rd_addr_q;
  assign rd_be     = rd_be_q;
  assign wr_addr   = wr_addr_q;
  assign wr_be     = wr_be_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pio_reg_master.sv
// Bench for pio_reg_master: directed and random commands against a
// transaction-level register-file model, with a bus-side register file.
module tb_pio_reg_master;
  import pio_reg_pkg::*;

  localparam int unsigned AW      = 14;
  localparam int unsigned RD_LAT  = 3;
  localparam int unsigned BUSY_TO = 12;
  localparam int unsigned NREG    = 64;

  logic          clk = 1'b0;
  logic          sys_rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_be;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0]   rsp_data;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [3:0]    rd_be;
  logic [31:0]   rd_data, wr_data;
  logic [7:0]    wr_be;
  logic          wr_en, wr_busy, busy;
  logic          preload;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] mem     [NREG];
  logic [31:0] exp_mem [NREG];
  logic [31:0] rd_pipe [RD_LAT];

  always #5 clk = ~clk;

  pio_reg_master #(
    .ADDR_W(AW), .RD_LATENCY(RD_LAT), .BUSY_TIMEOUT(BUSY_TO)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_err(rsp_err), .rsp_data(rsp_data),
    .rd_addr(rd_addr), .rd_be(rd_be), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_en(wr_en),
    .wr_busy(wr_busy), .busy(busy)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      int'(REG_STATUS): return 32'h0000_0001;
      int'(REG_PARAM):  return 32'h0016_0A10;
      int'(REG_ADDRH):  return 32'h0000_00AB;
      int'(REG_ADDRL):  return 32'h1234_5670;
      int'(REG_LENGTH): return 32'h0000_0400;
      int'(REG_TX_PPS): return 32'h0000_0008;
      int'(REG_DEBUG1): return 32'hDEAD_BEEF;
      default:          return 32'h9E37_79B9 ^ (32'(i) * 32'h0101_0101);
    endcase
  endfunction

  // Bus-side register file: big-endian enables, fixed read latency.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < int'(NREG); i++) mem[i] <= init_word(i);
    end else if (wr_en) begin
      for (int i = 0; i < 4; i++)
        if (wr_be[3-i]) mem[wr_addr[5:0]][8*i +: 8] <= wr_data[8*i +: 8];
    end
    rd_pipe[0] <= mem[rd_addr[5:0]];
    for (int k = 1; k < int'(RD_LAT); k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign rd_data = rd_pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_fields"}, 64'({rsp_write, rsp_err, rsp_data}), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_wr_en"}, 64'(wr_en), 64'(0));
    chk({tag, "_rd_bus"}, 64'({rd_addr, rd_be}), 64'(0));
    chk({tag, "_wr_bus"}, 64'({wr_addr, wr_be}), 64'(0));
    chk({tag, "_wr_data"}, 64'(wr_data), 64'(0));
  endtask

  // One complete command: accept, bus phase, response with optional stall.
  task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [3:0] be,
                         input logic [31:0] d, input int busy_cyc, input int stall);
    logic [3:0]  sbe;
    logic        err;
    int          n, pulses, want_n;
    logic [31:0] want_data;
    logic [63:0] frozen;
    for (int i = 0; i < 4; i++) sbe[3-i] = be[i];
    err       = w && (BUSY_TO != 0) && (busy_cyc >= int'(BUSY_TO));
    want_n    = !w ? int'(RD_LAT) + 1 : (err ? int'(BUSY_TO) : busy_cyc + 1);
    want_data = w ? 32'h0 : exp_mem[a[5:0]];

    chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_be = be; cmd_wdata = d;
    rsp_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_be = 4'($urandom);
    cmd_wdata = $urandom;

    n = 0; pulses = 0;
    while (!rsp_valid && n < 300) begin
      wr_busy = w ? (n < busy_cyc) : 1'($urandom);
      #1;
      if (w) begin
        chk("wr_en_vs_busy", 64'(wr_en), 64'(!wr_busy));
        if (wr_en) begin
          pulses++;
          chk("wr_addr", 64'(wr_addr), 64'(a));
          chk("wr_be", 64'(wr_be), 64'({4'b0000, sbe}));
          chk("wr_data", 64'(wr_data), 64'(d));
        end
      end else begin
        chk("wr_en_in_rd", 64'(wr_en), 64'(0));
        chk("rd_addr_hold", 64'(rd_addr), 64'(a));
        chk("rd_be", 64'(rd_be), 64'(sbe));
      end
      tick();
      n++;
    end
    wr_busy = 1'b0;
    #1;
    if (w && !err)
      for (int i = 0; i < 4; i++) if (be[i]) exp_mem[a[5:0]][8*i +: 8] = d[8*i +: 8];

    chk("rsp_cycles", 64'(n), 64'(want_n));
    chk("rsp_valid", 64'(rsp_valid), 64'(1));
    chk("wr_pulses", 64'(pulses), 64'((w && !err) ? 1 : 0));
    chk("rsp_write", 64'(rsp_write), 64'(w));
    chk("rsp_err", 64'(rsp_err), 64'(err));
    chk("rsp_data", 64'(rsp_data), 64'(want_data));
    chk("rd_addr_rsp", 64'({rd_addr, rd_be}), 64'(0));
    chk("rsp_state_outs", 64'({cmd_ready, busy, wr_en}), 64'(3'b010));

    frozen = 64'({rsp_valid, rsp_write, rsp_err, rsp_data});
    for (int k = 0; k < stall; k++) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      tick();
      chk("rsp_frozen", 64'({rsp_valid, rsp_write, rsp_err, rsp_data}), frozen);
      chk("cmd_ready_stall", 64'(cmd_ready), 64'(0));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_done", 64'(rsp_valid), 64'(0));
    chk("cmd_ready_after", 64'(cmd_ready), 64'(1));
    chk("busy_after", 64'(busy), 64'(0));
  endtask

  initial begin
    int r, bc;
    sys_rst_n = 1'b0; preload = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_be = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; wr_busy = 1'b0;
    for (int i = 0; i < int'(NREG); i++) exp_mem[i] = init_word(i);
    repeat (2) tick();
    preload = 1'b0;
    chk_idle_outs("reset");
    sys_rst_n = 1'b1;
    tick();

    // Directed: read, full write, read back, partial write with lane swap.
    run_cmd(1'b0, AW'(1), 4'hF, 32'h0, 0, 0);
    run_cmd(1'b1, AW'(1), 4'hF, 32'h1234_5678, 0, 0);
    run_cmd(1'b0, AW'(1), 4'hF, 32'h0, 0, 0);
    run_cmd(1'b1, AW'(5), 4'h1, 32'hAABB_CCDD, 0, 0);
    run_cmd(1'b0, AW'(5), 4'hF, 32'h0, 0, 0);
    // Upper address bits pass through unchanged.
    run_cmd(1'b1, AW'(14'h3F45), 4'h6, 32'h0102_0304, 0, 0);
    run_cmd(1'b0, AW'(14'h2A05), 4'hA, 32'h0, 0, 0);
    // Busy stall, watchdog edges and stuck busy.
    run_cmd(1'b1, AW'(6), 4'hF, 32'h0000_0800, 10, 0);
    run_cmd(1'b1, AW'(8), 4'hF, 32'h5555_AAAA, int'(BUSY_TO) - 1, 0);
    run_cmd(1'b1, AW'(8), 4'hF, 32'hFFFF_FFFF, int'(BUSY_TO), 0);
    run_cmd(1'b1, AW'(8), 4'hF, 32'hFFFF_0000, 1000, 0);
    run_cmd(1'b0, AW'(8), 4'hF, 32'h0, 0, 0);
    // Response backpressure.
    run_cmd(1'b0, AW'(16), 4'hC, 32'h0, 0, 5);
    run_cmd(1'b1, AW'(16), 4'h3, 32'h1111_2222, 3, 5);

    // Reset in the middle of a read drops it without a response.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'(5); cmd_be = 4'hF;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rd_addr_pre_rst", 64'(rd_addr), 64'(5));
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    chk_idle_outs("mid_rst");
    for (int k = 0; k < int'(RD_LAT) + 3; k++) begin
      tick();
      chk("no_rsp_after_rst", 64'(rsp_valid), 64'(0));
    end
    run_cmd(1'b1, AW'(5), 4'hF, 32'hCAFE_F00D, 0, 0);
    run_cmd(1'b0, AW'(5), 4'hF, 32'h0, 0, 0);

    // Random commands.
    for (int t = 0; t < 60; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)      bc = 0;
      else if (r < 8) bc = int'($urandom_range(1, BUSY_TO - 1));
      else            bc = int'($urandom_range(BUSY_TO, BUSY_TO + 5));
      run_cmd(1'($urandom), AW'($urandom), 4'($urandom), $urandom, bc,
              int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
